// File: rtl/wta_pkg.sv
// Shared sizing for the Wallace-tree final carry-propagate adder.
// Also provides the single-bit full-adder cell used to build the ripple chunks.
package wta_pkg;

  localparam int WTA_W = 64;
  localparam int WTA_H = WTA_W / 2;

  // Returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic cin);
    logic p;
    p = a ^ b;
    return {(a & b) | (cin & p), p ^ cin};
  endfunction

endpackage

// File: rtl/wta_cpa_chunk.sv
// Combinational N-bit ripple adder with carry-in and carry-out.
// Built as a chain of full-adder cells.
module wta_cpa_chunk
  import wta_pkg::*;
#(
  parameter int N = WTA_H
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign {c[i+1], sum[i]} = full_add(a[i], b[i], c[i]);
  end

  assign cout = c[N];

endmodule

// File: rtl/wta_final_cpa.sv
// Two-stage pipelined final adder for the Wallace-tree sum/carry rows.
// Low half is added in stage 1, high half plus the low carry in stage 2.
module wta_final_cpa
  import wta_pkg::*;
#(
  parameter int W = WTA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_sum,
  input  logic [W-1:0] in_carry,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic         out_cout
);

  localparam int H = W / 2;

  logic         load_p1;
  logic         load_p2;
  logic         vld_p1;
  logic         vld_p2;

  logic [H-1:0] lo_sum;
  logic         lo_cout;
  logic [H-1:0] lo_p1;
  logic         c_p1;
  logic [H-1:0] sum_hi_p1;
  logic [H-1:0] carry_hi_p1;

  logic [H-1:0] hi_sum;
  logic         hi_cout;
  logic [W-1:0] result_p2;
  logic         cout_p2;

  // Stage 2 may load whenever it is empty, so a bubble fills even under backpressure.
  assign load_p2  = !vld_p2 || out_ready;
  assign load_p1  = !vld_p1 || load_p2;
  assign in_ready = load_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (load_p1) vld_p1 <= in_valid;
      if (load_p2) vld_p2 <= vld_p1;
    end
  end

  // ---- stage 1: low half ----
  wta_cpa_chunk #(.N(H)) u_lo (
    .a    (in_sum[H-1:0]),
    .b    (in_carry[H-1:0]),
    .cin  (1'b0),
    .sum  (lo_sum),
    .cout (lo_cout)
  );

  always_ff @(posedge clk) begin
    if (load_p1 && in_valid) begin
      lo_p1       <= lo_sum;
      c_p1        <= lo_cout;
      sum_hi_p1   <= in_sum[W-1:H];
      carry_hi_p1 <= in_carry[W-1:H];
    end
  end

  // ---- stage 2: high half with carry from the low half ----
  wta_cpa_chunk #(.N(H)) u_hi (
    .a    (sum_hi_p1),
    .b    (carry_hi_p1),
    .cin  (c_p1),
    .sum  (hi_sum),
    .cout (hi_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      result_p2 <= '0;
      cout_p2   <= 1'b0;
    end else if (load_p2 && vld_p1) begin
      result_p2 <= {hi_sum, lo_p1};
      cout_p2   <= hi_cout;
    end
  end

  assign out_valid  = vld_p2;
  assign out_result = result_p2;
  assign out_cout   = cout_p2;

endmodule
